soc_system_mult_sequencer: RTL and testbench

Mailbox-driven multiply sequencer that owns the second port (s2) of the 4-word, 32-bit dual-port on-chip RAM in soc_system. The HPS writes two 16-bit operands and a START flag through port s1. This block polls the command word, fetches the operands, runs an iterative 16-cycle shift-add multiply, and writes the 32-bit product plus DONE status back through s2. It is the only master on s2; the RAM's clken2 is tied high and reset_req2 is tied low outside this block.

---
 rtl/soc_system_mult_seq_pkg.sv | 47 ++++
 rtl/soc_system_mult_sequencer_shiftadd.sv | 98 +++++++++
 rtl/soc_system_mult_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_soc_system_mult_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_mult_seq_pkg.sv
// -----------------------------------------------------------------------------
// soc_system_mult_seq_pkg
// Shared types and constants for the mailbox-driven multiply sequencer:
//   - sequencer FSM state enum
//   - RAM word addresses of the mailbox (A, B, result, command/status)
//   - command/status bit indices and the status words written back
//   - helper deciding whether a command word describes a fresh job
// -----------------------------------------------------------------------------
package soc_system_mult_seq_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 2;

  typedef enum logic [3:0] {
    ST_POLL_WAIT = 4'd0,
    ST_POLL_RD   = 4'd1,
    ST_POLL_CHK  = 4'd2,
    ST_CLAIM     = 4'd3,
    ST_RD_A      = 4'd4,
    ST_RD_B      = 4'd5,
    ST_LATCH_B   = 4'd6,
    ST_MULT      = 4'd7,
    ST_WR_RES    = 4'd8,
    ST_WR_STAT   = 4'd9
  } seq_state_t;

  localparam logic [ADDR_W-1:0] ADDR_A   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_B   = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_RES = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_CMD = 2'd3;

  localparam int CMD_START_BIT = 0;
  localparam int CMD_BUSY_BIT  = 1;
  localparam int CMD_DONE_BIT  = 2;

  localparam logic [DATA_W-1:0] CMD_BUSY = 32'h0000_0002;
  localparam logic [DATA_W-1:0] CMD_DONE = 32'h0000_0004;

  // A job is only taken when START is set and the host has cleared the
  // previous DONE; a stale DONE alongside START is ignored.
  function automatic logic is_new_job(input logic [DATA_W-1:0] cmd);
    return cmd[CMD_START_BIT] && !cmd[CMD_DONE_BIT];
  endfunction

endpackage

// File: rtl/soc_system_mult_sequencer_shiftadd.sv
// -----------------------------------------------------------------------------
// soc_system_mult_shiftadd
// Iterative 16x16 shift-add multiplier core.
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture operands and start a multiply
//   a, b       : multiplicand / multiplier (16 bit)
//   busy       : high while iterations remain; drops in the final cycle
//   product    : 32-bit result, valid once busy has dropped
// The load edge already accumulates multiplier bit 0; the next 15 cycles
// (counter 0..14) accumulate bits 1..15 and counter value 15 is the cycle in
// which the finished product is presented, so the run spans 16 cycles and
// the caller can register the result on the edge that ends it.
// Build option MULT_SIGNED_EN: operands are two's complement; the core
// multiplies magnitudes and negates the product when exactly one operand is
// negative. Without it no sign logic exists.
// -----------------------------------------------------------------------------
module soc_system_mult_shiftadd
  import soc_system_mult_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic [PROD_W-1:0] product
);

  logic [PROD_W-1:0] mcand_r;
  logic [PROD_W-1:0] acc_r;
  logic [OP_W-1:0]   mplier_r;
  logic [3:0]        cnt_r;
  logic              run_r;
  logic [OP_W-1:0]   a_mag_s;
  logic [OP_W-1:0]   b_mag_s;
`ifdef MULT_SIGNED_EN
  logic              neg_r;
`endif

  // Operand magnitudes fed to the unsigned shift-add engine.
  always_comb begin
`ifdef MULT_SIGNED_EN
    a_mag_s = a[OP_W-1] ? (~a + 16'd1) : a;
    b_mag_s = b[OP_W-1] ? (~b + 16'd1) : b;
`else
    a_mag_s = a;
    b_mag_s = b;
`endif
  end

  // Iteration counter, shifted multiplicand/multiplier and accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_r  <= 32'd0;
      acc_r    <= 32'd0;
      mplier_r <= 16'd0;
      cnt_r    <= 4'd0;
      run_r    <= 1'b0;
`ifdef MULT_SIGNED_EN
      neg_r    <= 1'b0;
`endif
    end else if (load) begin
      mcand_r  <= {15'd0, a_mag_s, 1'b0};
      mplier_r <= {1'b0, b_mag_s[OP_W-1:1]};
      acc_r    <= b_mag_s[0] ? {16'd0, a_mag_s} : 32'd0;
      cnt_r    <= 4'd0;
      run_r    <= 1'b1;
`ifdef MULT_SIGNED_EN
      neg_r    <= a[OP_W-1] ^ b[OP_W-1];
`endif
    end else if (run_r) begin
      if (cnt_r != 4'd15) begin
        if (mplier_r[0]) begin
          acc_r <= acc_r + mcand_r;
        end else begin
          acc_r <= acc_r;
        end
        mcand_r  <= {mcand_r[PROD_W-2:0], 1'b0};
        mplier_r <= {1'b0, mplier_r[OP_W-1:1]};
        cnt_r    <= cnt_r + 4'd1;
      end else begin
        run_r <= 1'b0;
        cnt_r <= 4'd0;
      end
    end else begin
      run_r <= 1'b0;
    end
  end

  assign busy = run_r && (cnt_r != 4'd15);

`ifdef MULT_SIGNED_EN
  assign product = neg_r ? (~acc_r + 32'd1) : acc_r;
`else
  assign product = acc_r;
`endif

endmodule

// File: rtl/soc_system_mult_sequencer.sv
// -----------------------------------------------------------------------------
// soc_system_mult_sequencer
// Mailbox-driven multiply sequencer; sole master on port s2 of the 4-word
// dual-port RAM. Polls word3 for START, claims the job (word3=0x2), reads A
// and B, multiplies, writes the product to word2 and DONE (0x4) to word3.
// Parameters:
//   POLL_DIV        idle cycles between command polls (>=1)
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   enable          low: no new job is accepted (a running job completes)
//   ram_address/chipselect/write/byteenable/writedata  RAM s2 drive
//   ram_readdata    RAM s2 q, valid the cycle after the address
//   busy            high from CLAIM through WR_STAT
//   done_pulse      one cycle, coincident with the WR_STAT status write
// Build option MULT_SIGNED_EN selects two's-complement operands (see core).
// All port outputs are registered; they are decoded from the next state so
// that each state's bus values appear during that state's own cycle.
// -----------------------------------------------------------------------------
module soc_system_mult_sequencer
  import soc_system_mult_seq_pkg::*;
#(
  parameter int POLL_DIV = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [3:0]        ram_byteenable,
  output logic [DATA_W-1:0] ram_writedata,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic              busy,
  output logic              done_pulse
);

  localparam int PCNT_W = $clog2(POLL_DIV + 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(POLL_DIV - 1);

  seq_state_t        state_r;
  seq_state_t        next_s;
  logic [PCNT_W-1:0] poll_cnt_r;
  logic [PCNT_W-1:0] poll_cnt_next_s;
  logic [OP_W-1:0]   a_r;

  logic              mult_load_s;
  logic              mult_busy_s;
  logic [PROD_W-1:0] mult_product_s;

  logic [ADDR_W-1:0] addr_next_s;
  logic              cs_next_s;
  logic              we_next_s;
  logic [DATA_W-1:0] wd_next_s;
  logic              busy_next_s;
  logic              done_next_s;

  soc_system_mult_shiftadd u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (mult_load_s),
    .a       (a_r),
    .b       (ram_readdata[OP_W-1:0]),
    .busy    (mult_busy_s),
    .product (mult_product_s)
  );

  // Next-state and poll-counter logic.
  always_comb begin
    next_s          = state_r;
    poll_cnt_next_s = poll_cnt_r;
    mult_load_s     = 1'b0;
    case (state_r)
      ST_POLL_WAIT: begin
        if (!enable) begin
          poll_cnt_next_s = '0;
        end else if (poll_cnt_r == PCNT_LAST) begin
          poll_cnt_next_s = '0;
          next_s          = ST_POLL_RD;
        end else begin
          poll_cnt_next_s = poll_cnt_r + PCNT_W'(1);
        end
      end
      ST_POLL_RD: next_s = ST_POLL_CHK;
      ST_POLL_CHK: begin
        // enable is rechecked here so a drop during the read still blocks.
        if (enable && is_new_job(ram_readdata)) begin
          next_s = ST_CLAIM;
        end else begin
          next_s = ST_POLL_WAIT;
        end
      end
      ST_CLAIM:   next_s = ST_RD_A;
      ST_RD_A:    next_s = ST_RD_B;
      ST_RD_B:    next_s = ST_LATCH_B;
      ST_LATCH_B: begin
        // B arrives on readdata this cycle; load it straight into the core.
        mult_load_s = 1'b1;
        next_s      = ST_MULT;
      end
      ST_MULT: begin
        if (!mult_busy_s) begin
          next_s = ST_WR_RES;
        end else begin
          next_s = ST_MULT;
        end
      end
      ST_WR_RES:  next_s = ST_WR_STAT;
      ST_WR_STAT: next_s = ST_POLL_WAIT;
      default: begin
        next_s          = ST_POLL_WAIT;
        poll_cnt_next_s = '0;
      end
    endcase
  end

  // RAM-port and status values for the state being entered.
  always_comb begin
    addr_next_s = ADDR_A;
    cs_next_s   = 1'b0;
    we_next_s   = 1'b0;
    wd_next_s   = 32'd0;
    busy_next_s = 1'b0;
    done_next_s = 1'b0;
    case (next_s)
      ST_POLL_RD: begin
        cs_next_s   = 1'b1;
        addr_next_s = ADDR_CMD;
      end
      ST_CLAIM: begin
        cs_next_s   = 1'b1;
        we_next_s   = 1'b1;
        addr_next_s = ADDR_CMD;
        wd_next_s   = CMD_BUSY;
        busy_next_s = 1'b1;
      end
      ST_RD_A: begin
        cs_next_s   = 1'b1;
        addr_next_s = ADDR_A;
        busy_next_s = 1'b1;
      end
      ST_RD_B: begin
        cs_next_s   = 1'b1;
        addr_next_s = ADDR_B;
        busy_next_s = 1'b1;
      end
      ST_LATCH_B: busy_next_s = 1'b1;
      ST_MULT:    busy_next_s = 1'b1;
      ST_WR_RES: begin
        // Core has presented its final (sign-corrected) product by now.
        cs_next_s   = 1'b1;
        we_next_s   = 1'b1;
        addr_next_s = ADDR_RES;
        wd_next_s   = mult_product_s;
        busy_next_s = 1'b1;
      end
      ST_WR_STAT: begin
        cs_next_s   = 1'b1;
        we_next_s   = 1'b1;
        addr_next_s = ADDR_CMD;
        wd_next_s   = CMD_DONE;
        busy_next_s = 1'b1;
        done_next_s = 1'b1;
      end
      default: begin
        cs_next_s = 1'b0;
      end
    endcase
  end

  // State, poll counter and registered port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_POLL_WAIT;
      poll_cnt_r     <= '0;
      ram_address    <= 2'd0;
      ram_chipselect <= 1'b0;
      ram_write      <= 1'b0;
      ram_byteenable <= 4'b0000;
      ram_writedata  <= 32'd0;
      busy           <= 1'b0;
      done_pulse     <= 1'b0;
    end else begin
      state_r        <= next_s;
      poll_cnt_r     <= poll_cnt_next_s;
      ram_address    <= addr_next_s;
      ram_chipselect <= cs_next_s;
      ram_write      <= we_next_s;
      ram_byteenable <= cs_next_s ? 4'b1111 : 4'b0000;
      ram_writedata  <= wd_next_s;
      busy           <= busy_next_s;
      done_pulse     <= done_next_s;
    end
  end

  // Operand A register; word0 data is on readdata during RD_B.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r <= 16'd0;
    end else if (state_r == ST_RD_B) begin
      a_r <= ram_readdata[OP_W-1:0];
    end else begin
      a_r <= a_r;
    end
  end

endmodule

// File: tb/tb_soc_system_mult_sequencer.sv
module tb_soc_system_mult_sequencer;

  localparam int POLL_DIV    = 8;
  localparam int DONE_BUDGET = POLL_DIV + 24;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  ram_address;
  logic        ram_chipselect;
  logic        ram_write;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;
  logic        busy;
  logic        done_pulse;

  // RAM model: s1 is the host, s2 is the DUT; q is mem at the registered address.
  logic [31:0] mem [4];
  logic [1:0]  q_addr;
  logic        h_we = 1'b0;
  logic [1:0]  h_addr = 2'd0;
  logic [31:0] h_wd = 32'd0;

  int n_pass = 0;
  int n_total = 0;

  logic        allow_job = 1'b0;
  logic [31:0] exp_prod = 32'd0;
  int          cyc = 0;
  int          claim_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  logic        busy_q = 1'b0;

  always #5 clk = ~clk;

  assign ram_readdata = mem[q_addr];

  always @(posedge clk) begin
    if (h_we) mem[h_addr] <= h_wd;
    if (ram_chipselect && ram_write) mem[ram_address] <= ram_writedata;
    q_addr <= ram_address;
  end

  soc_system_mult_sequencer #(.POLL_DIV(POLL_DIV)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_byteenable (ram_byteenable),
    .ram_writedata  (ram_writedata),
    .ram_readdata   (ram_readdata),
    .busy           (busy),
    .done_pulse     (done_pulse)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference multiply straight from the arithmetic definition.
  function automatic logic [31:0] model_mult(input logic [15:0] a, input logic [15:0] b);
`ifdef MULT_SIGNED_EN
    logic signed [31:0] sa, sb, p;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    p  = sa * sb;
    return p;
`else
    return {16'd0, a} * {16'd0, b};
`endif
  endfunction

  // Per-cycle compare process against the bus rules and the model product.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      chk("byteenable", {28'd0, ram_byteenable}, ram_chipselect ? 32'hF : 32'h0);
      if (!ram_chipselect) begin
        chk("idle_addr_write", {29'd0, ram_write, ram_address}, 32'd0);
        chk("idle_writedata", ram_writedata, 32'd0);
      end
      if (!allow_job) chk("no_job_activity", {30'd0, busy, ram_write}, 32'd0);
      if (ram_chipselect && ram_write) begin
        chk("write_target", {31'd0, ram_address[1]}, 32'd1);
        if (ram_address == 2'd2) chk("result_write", ram_writedata, exp_prod);
        if (ram_address == 2'd3) chk("status_write", ram_writedata, done_pulse ? 32'h4 : 32'h2);
      end
      if (done_pulse) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_with_busy", {31'd0, busy}, 32'd1);
      end
      if (busy && !busy_q) claim_cyc = cyc;
      busy_q = busy;
    end
  end

  task automatic host_wr(input logic [1:0] a, input logic [31:0] d);
    h_addr = a;
    h_wd   = d;
    h_we   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    h_we   = 1'b0;
  endtask

  task automatic wait_job(input string tag, output logic [31:0] res);
    int   n0;
    logic found;
    n0 = done_cnt;
    found = 1'b0;
    for (int i = 0; i < DONE_BUDGET && !found; i++) begin
      if (done_pulse) found = 1'b1;
      else @(negedge clk);
    end
    chk($sformatf("%s_done_in_time", tag), {31'd0, found}, 32'd1);
    repeat (POLL_DIV + 4) @(negedge clk);
    chk($sformatf("%s_pulse_count", tag), done_cnt - n0, 32'd1);
    if (found) chk($sformatf("%s_latency", tag), done_cyc - claim_cyc, 32'd21);
    res = mem[2];
    chk($sformatf("%s_product", tag), res, exp_prod);
    chk($sformatf("%s_status", tag), mem[3], 32'h4);
    host_wr(2'd3, 32'd0);
  endtask

  task automatic run_job(input string tag, input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] res);
    exp_prod  = model_mult(a, b);
    allow_job = 1'b1;
    host_wr(2'd0, {16'd0, a});
    host_wr(2'd1, {16'd0, b});
    host_wr(2'd3, 32'd1);
    wait_job(tag, res);
  endtask

  initial begin
    logic [31:0] r;
    logic        found;
    reset  = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) host_wr(i[1:0], 32'd0);
    chk("reset_ctrl", {24'd0, ram_chipselect, ram_write, busy, done_pulse, ram_address, 2'd0}, 32'd0);
    chk("reset_wdata", ram_writedata, 32'd0);
    chk("reset_be", {28'd0, ram_byteenable}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    run_job("j_3x5", 16'd3, 16'd5, r);
    chk("j_3x5_literal", r, 32'd15);

    run_job("j_zero", 16'h0000, 16'hFFFF, r);
    chk("j_zero_literal", r, 32'd0);

    run_job("j_ffff", 16'hFFFF, 16'hFFFF, r);
`ifdef MULT_SIGNED_EN
    chk("j_ffff_literal", r, 32'h0000_0001);
`else
    chk("j_ffff_literal", r, 32'hFFFE_0001);
`endif

    run_job("j_m3x7", 16'hFFFD, 16'd7, r);
`ifdef MULT_SIGNED_EN
    chk("j_m3x7_literal", r, 32'hFFFF_FFEB);
`else
    chk("j_m3x7_literal", r, 32'h0006_FFEB);
`endif

    // Reset during MULT cycle 8 of a job.
    exp_prod  = model_mult(16'd6, 16'd9);
    allow_job = 1'b1;
    host_wr(2'd0, 32'd6);
    host_wr(2'd1, 32'd9);
    host_wr(2'd3, 32'd1);
    found = 1'b0;
    for (int i = 0; i < DONE_BUDGET && !found; i++) begin
      if (busy) found = 1'b1;
      else @(negedge clk);
    end
    chk("abort_claimed", {31'd0, found}, 32'd1);
    repeat (11) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    allow_job = 1'b0;
    #1;
    chk("abort_ctrl_zero", {24'd0, ram_chipselect, ram_write, busy, done_pulse, ram_byteenable}, 32'd0);
    chk("abort_bus_zero", {30'd0, ram_address} | ram_writedata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_word3", mem[3], 32'h2);
    repeat (3 * (POLL_DIV + 2)) @(negedge clk);
    chk("abort_word3_kept", mem[3], 32'h2);
    host_wr(2'd3, 32'd0);
    run_job("j_recover", 16'd2, 16'd2, r);
    chk("j_recover_literal", r, 32'd4);

    // START with stale DONE is ignored.
    allow_job = 1'b0;
    host_wr(2'd0, 32'd7);
    host_wr(2'd1, 32'd7);
    host_wr(2'd3, 32'h5);
    repeat (10 * (POLL_DIV + 2)) @(negedge clk);
    chk("stale_word3", mem[3], 32'h5);
    chk("stale_word2", mem[2], 32'd4);
    host_wr(2'd3, 32'd0);

    // enable low holds off a pending START; raising it lets the job run.
    enable = 1'b0;
    host_wr(2'd0, 32'd4);
    host_wr(2'd1, 32'd11);
    host_wr(2'd3, 32'd1);
    repeat (5 * (POLL_DIV + 2)) @(negedge clk);
    chk("disabled_word3", mem[3], 32'h1);
    chk("disabled_word2", mem[2], 32'd4);
    exp_prod  = model_mult(16'd4, 16'd11);
    allow_job = 1'b1;
    enable    = 1'b1;
    wait_job("j_enable", r);
    chk("j_enable_literal", r, 32'd44);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
